alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, command FIFO depth (power of two, >= 2).
REQ-002 The block SHALL have parameter SETTLE, default 1, extra cycles operands are held on the ALU before capture (0..15).
REQ-003 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-004 The block SHALL have a port clk, input, 1 bit, the sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have a port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have a port cmd_valid, input, 1 bit, command present.
REQ-007 The block SHALL have a port cmd_ready, output, 1 bit, FIFO can accept a command.
REQ-008 The block SHALL have a port cmd_oper, input, 2 bits: 00 add, 01 mul, 10 sub, 11 div.
REQ-009 The block SHALL have ports cmd_in1 and cmd_in2, input, 4 bits each, operands.
REQ-010 The block SHALL have ports alu_oper (output, 2 bits), alu_in1 and alu_in2 (output, 4 bits each), registered drive to the downstream ALU.
REQ-011 The block SHALL have a port alu_out, input, 5 bits, ALU result.
REQ-012 The block SHALL have a port res_valid, output, 1 bit, result available.
REQ-013 The block SHALL have a port res_ready, input, 1 bit, consumer accepts the result.
REQ-014 The block SHALL have a port res_data, output, 5 bits, captured alu_out.
REQ-015 The block SHALL have a port res_oper, output, 2 bits, opcode of the captured result.
REQ-016 The block SHALL have a port res_divz, output, 1 bit, divide-by-zero flag (see Configuration).

Function
REQ-017 The block SHALL push a command into the FIFO at an edge where cmd_valid && cmd_ready.
REQ-018 cmd_ready SHALL equal (registered count < DEPTH); a pop in the same cycle SHALL NOT raise cmd_ready until the next cycle.
REQ-019 The FSM SHALL have states IDLE, DRIVE, HOLD.
REQ-020 In IDLE with the FIFO non-empty, the block SHALL pop the head, load alu_oper/alu_in1/alu_in2, load the settle counter with SETTLE, and go to DRIVE; with the FIFO empty it SHALL stay in IDLE.
REQ-021 In DRIVE, the block SHALL decrement the counter each cycle; at the edge where the counter is 0 it SHALL capture alu_out into res_data, alu_oper into res_oper, set res_valid=1, and go to HOLD.
REQ-022 alu_* outputs SHALL hold their value until the next pop, including in IDLE.
REQ-023 In HOLD, res_valid, res_data, res_oper and res_divz SHALL stay stable until res_valid && res_ready; at that edge res_valid SHALL clear and the FSM SHALL go to IDLE.
REQ-024 Latency: a command accepted at edge N into an empty FIFO with the FSM idle SHALL produce res_valid=1 after edge N+2+SETTLE.
REQ-025 With res_ready held at 1 and the FIFO non-empty, results SHALL issue one per SETTLE+3 cycles.
REQ-026 With res_ready=0, the block SHALL accept exactly DEPTH+1 commands (one in flight, DEPTH queued) and then hold cmd_ready=0.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH, and order SHALL be strictly FIFO.
REQ-028 res_data SHALL be alu_out unmodified (5 bits), with no truncation or sign handling in this block.

Reset
REQ-029 When rst=1 at an edge, the block SHALL empty the FIFO and set state to IDLE, cmd_ready=1 on the following cycle, alu_oper/alu_in1/alu_in2=0, res_valid=0, res_data=0, res_oper=0, res_divz=0, and the counter to 0.
REQ-030 A reset mid-operation (DRIVE or HOLD) SHALL discard the in-flight command, the pending result and all queued commands, with no result emitted.
REQ-031 While rst=1, the block SHALL ignore cmd_valid.

Configuration
REQ-032 With macro ALU_ISSUE_DIVZ_FLAG_EN defined, res_divz SHALL be captured alongside res_data as (alu_oper==2'b11 && alu_in2==0).
REQ-033 With ALU_ISSUE_DIVZ_FLAG_EN undefined, the res_divz port SHALL still exist and SHALL be constant 0.

Verification
REQ-034 The bench SHALL cover: SETTLE=1, accept add 7+9 at edge N -> res_valid after edge N+3, res_data=16, res_oper=00.
REQ-035 The bench SHALL cover: mul 15*15 then sub 3-9 back-to-back, res_ready=1 -> res_data=1 then 26, in order, 4 cycles apart.
REQ-036 The bench SHALL cover: res_ready=0, 6 commands offered -> 5 accepted, cmd_ready=0; first result stable for 10 cycles; releasing res_ready drains 5 results in order.
REQ-037 The bench SHALL cover: div 5/0 with ALU_ISSUE_DIVZ_FLAG_EN defined -> res_data=0, res_divz=1; without the macro -> res_divz=0.
REQ-038 The bench SHALL cover: rst pulsed during DRIVE with 3 queued -> no res_valid, cmd_ready=1, all outputs 0; a new add 1+1 -> res_data=2.
REQ-039 The bench SHALL cover: DEPTH=4, 12 commands with random res_ready -> all 12 results in order, FIFO wrapped 3 times.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Command FIFO plus issue FSM that drives a downstream ALU, waits SETTLE cycles, and holds the
// captured result until accepted. Define ALU_ISSUE_DIVZ_FLAG_EN to enable the res_divz flag.
module alu_issue_ctrl #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_oper,
    input  logic [3:0] cmd_in1,
    input  logic [3:0] cmd_in2,
    output logic [1:0] alu_oper,
    output logic [3:0] alu_in1,
    output logic [3:0] alu_in2,
    input  logic [4:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [4:0] res_data,
    output logic [1:0] res_oper,
    output logic       res_divz
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

    state_e        state_q;
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [3:0]    settle_q;
    logic          push;
    logic          pop;
    logic [9:0]    head;

    // Ready comes only from the registered count, so a same-cycle pop frees space a cycle later.
    assign cmd_ready = (count_q < CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {cmd_oper, cmd_in1, cmd_in2};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

`ifdef ALU_ISSUE_DIVZ_FLAG_EN
    logic divz_q;
    assign res_divz = divz_q;
`else
    assign res_divz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            alu_oper  <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            settle_q  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_oper  <= '0;
`ifdef ALU_ISSUE_DIVZ_FLAG_EN
            divz_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        {alu_oper, alu_in1, alu_in2} <= head;
                        settle_q                     <= 4'(SETTLE);
                        state_q                      <= StDrive;
                    end
                end
                StDrive: begin
                    if (settle_q == 4'd0) begin
                        res_data  <= alu_out;
                        res_oper  <= alu_oper;
                        res_valid <= 1'b1;
`ifdef ALU_ISSUE_DIVZ_FLAG_EN
                        divz_q    <= (alu_oper == 2'b11) && (alu_in2 == 4'd0);
`endif
                        state_q   <= StHold;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                StHold: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus a randomized run, all checked
// against a result queue computed from the commands with plain arithmetic.
module tb_alu_issue_ctrl;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 1;
`ifdef ALU_ISSUE_DIVZ_FLAG_EN
    localparam bit DivzEn = 1'b1;
`else
    localparam bit DivzEn = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_oper;
    logic [3:0] cmd_in1;
    logic [3:0] cmd_in2;
    logic [1:0] alu_oper;
    logic [3:0] alu_in1;
    logic [3:0] alu_in2;
    logic [4:0] alu_out;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_data;
    logic [1:0] res_oper;
    logic       res_divz;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] exp_q[$];  // {divz, oper, data}

    alu_issue_ctrl #(
        .DEPTH (DEPTH),
        .SETTLE(SETTLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_oper (cmd_oper),
        .cmd_in1  (cmd_in1),
        .cmd_in2  (cmd_in2),
        .alu_oper (alu_oper),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_out  (alu_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_oper (res_oper),
        .res_divz (res_divz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 5-bit wrap-around arithmetic; divide by zero yields 0.
    function automatic logic [4:0] alu_calc(input logic [1:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
        int r;
        case (op)
            2'b00:   r = int'(a) + int'(b);
            2'b01:   r = int'(a) * int'(b);
            2'b10:   r = int'(a) - int'(b) + 32;
            default: r = (b == 4'd0) ? 0 : int'(a) / int'(b);
        endcase
        return 5'(r % 32);
    endfunction

    function automatic logic [7:0] model(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        logic dz;
        dz = DivzEn && (op == 2'b11) && (b == 4'd0);
        return {dz, op, alu_calc(op, a, b)};
    endfunction

    // Downstream ALU.
    always_comb alu_out = alu_calc(alu_oper, alu_in1, alu_in2);

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic take_head(input string tag);
        logic [7:0] e;
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_order: observed extra result %0h expected none", tag, res_data);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(res_data), 32'(e[4:0]));
            check({tag, "_oper"}, 32'(res_oper), 32'(e[6:5]));
            check({tag, "_divz"}, 32'(res_divz), 32'(e[7]));
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        cmd_valid = 1'b1;
        cmd_oper  = op;
        cmd_in1   = a;
        cmd_in2   = b;
        for (int i = 0; i < 64 && !cmd_ready; i++) tick();
        check("send_ready", 32'(cmd_ready), 32'd1);
        if (cmd_ready) exp_q.push_back(model(op, a, b));
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 64 && !res_valid; i++) tick();
        check({tag, "_timeout"}, 32'(res_valid), 32'd1);
    endtask

    task automatic expect_result(input string tag, output int stamp);
        wait_valid(tag);
        stamp = cyc;
        if (res_valid) take_head(tag);
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_data"}, 32'(res_data), 32'd0);
        check({tag, "_res_oper"}, 32'(res_oper), 32'd0);
        check({tag, "_res_divz"}, 32'(res_divz), 32'd0);
        check({tag, "_alu"}, 32'({alu_oper, alu_in1, alu_in2}), 32'd0);
    endtask

    initial begin
        int t0;
        int t1;
        int sent;
        int got;
        logic [3:0] a;
        logic [3:0] b;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_oper  = '0;
        cmd_in1   = '0;
        cmd_in2   = '0;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");

        // Latency: add 7+9 accepted at edge N, valid after edge N+2+SETTLE.
        res_ready = 1'b1;
        send(2'b00, 4'd7, 4'd9);
        for (int i = 0; i < int'(SETTLE) + 2; i++) begin
            check("lat_not_yet", 32'(res_valid), 32'd0);
            tick();
        end
        check("lat_valid", 32'(res_valid), 32'd1);
        take_head("add");
        tick();
        check("add_cleared", 32'(res_valid), 32'd0);
        check("alu_hold_idle", 32'({alu_oper, alu_in1, alu_in2}), 32'({2'b00, 4'd7, 4'd9}));

        // Back-to-back mul then sub, one result per SETTLE+3 cycles.
        send(2'b01, 4'd15, 4'd15);
        send(2'b10, 4'd3, 4'd9);
        expect_result("mul", t0);
        expect_result("sub", t1);
        check("issue_spacing", 32'(t1 - t0), 32'(SETTLE + 3));

        // Backpressure: DEPTH+1 accepted, result held stable, then drained in order.
        res_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            cmd_valid = 1'b1;
            cmd_oper  = 2'(i);
            cmd_in1   = 4'(i + 3);
            cmd_in2   = 4'(i + 1);
            check("fill_ready", 32'(cmd_ready), 32'(i < int'(DEPTH) + 1));
            if (cmd_ready) exp_q.push_back(model(cmd_oper, cmd_in1, cmd_in2));
            tick();
        end
        cmd_valid = 1'b0;
        wait_valid("hold");
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", 32'(res_data), 32'(exp_q[0][4:0]));
            check("hold_full", 32'(cmd_ready), 32'd0);
            tick();
        end
        res_ready = 1'b1;
        for (int i = 0; i < int'(DEPTH) + 1; i++) expect_result("drain", t0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // Divide by zero and a regular divide.
        send(2'b11, 4'd5, 4'd0);
        expect_result("div0", t0);
        send(2'b11, 4'd9, 4'd2);
        expect_result("div", t0);

        // Reset while DRIVE is active with three commands queued.
        res_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH) + 1; i++) send(2'b00, 4'(i), 4'd1);
        wait_valid("pre_rst");
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_oper  = 2'b00;
        cmd_in1   = 4'd4;
        cmd_in2   = 4'd4;
        tick();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        exp_q.delete();
        check_reset_state("mid_rst");
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("post_rst_quiet", 32'(res_valid), 32'd0);
            tick();
        end
        send(2'b00, 4'd1, 4'd1);
        expect_result("post_rst_add", t0);

        // Randomized traffic with random backpressure.
        sent = 0;
        got  = 0;
        for (int c = 0; c < 3000 && got < 12; c++) begin
            a         = 4'($urandom_range(0, 15));
            b         = 4'($urandom_range(0, 15));
            cmd_valid = (sent < 12) && ($urandom_range(0, 3) != 0);
            cmd_oper  = 2'($urandom_range(0, 3));
            cmd_in1   = a;
            cmd_in2   = b;
            res_ready = 1'($urandom_range(0, 1));
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(model(cmd_oper, a, b));
                sent++;
            end
            if (res_valid && res_ready) begin
                take_head("rand");
                got++;
            end
            tick();
        end
        cmd_valid = 1'b0;
        check("rand_count", 32'(got), 32'd12);
        check("rand_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
